slice_add_sequencer: RTL and testbench

SLICE_ADD_SEQUENCER -- requirements
Module: slice_add_sequencer

---
 rtl/slice_add_sequencer.sv | 156 +++++++++++++++
 tb/tb_slice_add_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/slice_add_sequencer.sv
// ---------------------------------------------------------------------------
// slice_add_sequencer
//
// Performs a WIDTH-bit addition (in_a + in_b + in_cin) using an external
// SLICE-bit combinational adder, one slice per clock, least-significant
// slice first. The carry ripples between slices through an internal carry
// register.
//
// Sequence: IDLE (accept operands) -> RUN (NSLICE cycles) -> DONE (hold
// the result until the consumer takes it) -> IDLE.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : operand pair offered
//   in_ready   : block can accept operands (IDLE and not in reset)
//   in_a/in_b  : WIDTH-bit operands
//   in_cin     : carry-in of the full-width add
//   add_a/b    : operand slice presented to the external adder
//   add_cin    : carry-in presented to the external adder
//   add_sum    : sum returned by the external adder (combinational)
//   add_cout   : carry-out returned by the external adder (combinational)
//   out_valid  : result available
//   out_ready  : consumer accepts the result
//   out_sum    : assembled WIDTH-bit sum
//   out_cout   : final carry-out
// ---------------------------------------------------------------------------
module slice_add_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [SLICE-1:0] add_a,
  output logic [SLICE-1:0] add_b,
  output logic             add_cin,
  input  logic [SLICE-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int NSLICE = WIDTH / SLICE;
  // Keep the index at least one bit wide so NSLICE == 1 still elaborates.
  localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

  if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_param
    $error("slice_add_sequencer: WIDTH must be a positive multiple of SLICE");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q,     a_d;
  logic [WIDTH-1:0]   b_q,     b_d;
  logic [WIDTH-1:0]   sum_q,   sum_d;
  logic               cout_q,  cout_d;

  // Bit offset of the slice currently being processed.
  int unsigned        base;

  assign base = int'(idx_q) * SLICE;

  // Held low during reset so no operand can be taken while the block is
  // being cleared.
  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        add_a   = a_q[base +: SLICE];
        add_b   = b_q[base +: SLICE];
        add_cin = carry_q;
        // Previous result slices stay visible until overwritten here.
        sum_d[base +: SLICE] = add_sum;
        carry_d = add_cout;
        if (idx_q == IDX_LAST) begin
          cout_d  = add_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

endmodule

// File: tb/tb_slice_add_sequencer.sv
// ---------------------------------------------------------------------------
// tb_slice_add_sequencer
//
// Directed bench for slice_add_sequencer. Three instances share clock,
// reset and operand buses: index 0 is WIDTH=32/SLICE=8, index 1 is
// SLICE=32 (one slice), index 2 is SLICE=1 (32 slices). Each instance has
// its own behavioural slice adder and its own handshake signals.
// ---------------------------------------------------------------------------
module tb_slice_add_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] a, b;
  logic        cin;

  logic [2:0]        vld, rdy, ov, oc, ordy;
  logic [2:0][31:0]  os;

  // Instance 0 adder (8-bit slices)
  logic [7:0]  m_add_a, m_add_b, m_add_sum;
  logic        m_add_cin, m_add_cout;
  assign {m_add_cout, m_add_sum} = 9'(m_add_a) + 9'(m_add_b) + 9'(m_add_cin);

  // Instance 1 adder (32-bit slice)
  logic [31:0] w_add_a, w_add_b, w_add_sum;
  logic        w_add_cin, w_add_cout;
  assign {w_add_cout, w_add_sum} = 33'(w_add_a) + 33'(w_add_b) + 33'(w_add_cin);

  // Instance 2 adder (1-bit slices)
  logic        n_add_a, n_add_b, n_add_sum;
  logic        n_add_cin, n_add_cout;
  assign {n_add_cout, n_add_sum} = 2'(n_add_a) + 2'(n_add_b) + 2'(n_add_cin);

  slice_add_sequencer #(.WIDTH(32), .SLICE(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(vld[0]), .in_ready(rdy[0]),
    .in_a(a), .in_b(b), .in_cin(cin),
    .add_a(m_add_a), .add_b(m_add_b), .add_cin(m_add_cin),
    .add_sum(m_add_sum), .add_cout(m_add_cout),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_sum(os[0]), .out_cout(oc[0])
  );

  slice_add_sequencer #(.WIDTH(32), .SLICE(32)) u_dut_w (
    .clk(clk), .rst_n(rst_n),
    .in_valid(vld[1]), .in_ready(rdy[1]),
    .in_a(a), .in_b(b), .in_cin(cin),
    .add_a(w_add_a), .add_b(w_add_b), .add_cin(w_add_cin),
    .add_sum(w_add_sum), .add_cout(w_add_cout),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_sum(os[1]), .out_cout(oc[1])
  );

  slice_add_sequencer #(.WIDTH(32), .SLICE(1)) u_dut_n (
    .clk(clk), .rst_n(rst_n),
    .in_valid(vld[2]), .in_ready(rdy[2]),
    .in_a(a), .in_b(b), .in_cin(cin),
    .add_a(n_add_a), .add_b(n_add_b), .add_cin(n_add_cin),
    .add_sum(n_add_sum), .add_cout(n_add_cout),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_sum(os[2]), .out_cout(oc[2])
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rec_a[$];
  logic       rec_cin[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one operand pair to instance k, then wait for out_valid.
  // Returns the number of rising edges from the accepting edge to out_valid.
  // Starts and ends just after a rising edge.
  task automatic txn(input int k, input logic [31:0] ta, input logic [31:0] tb,
                     input logic tc, output int lat);
    int n;
    a = ta; b = tb; cin = tc;
    vld[k] = 1'b1;
    n = 0;
    while (!rdy[k] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("ready_wait", 64'(rdy[k]), 64'd1);
    @(posedge clk); #1;
    vld[k] = 1'b0;
    rec_a.delete();
    rec_cin.delete();
    lat = 0;
    while (!ov[k] && lat < 100) begin
      if (k == 0) begin
        rec_a.push_back(m_add_a);
        rec_cin.push_back(m_add_cin);
      end
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_out(input int k);
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
    check("ov_drop", 64'(ov[k]), 64'd0);
    check("ready_back", 64'(rdy[k]), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acc[$];
    logic [32:0] res[$];
    logic [31:0] ta[2];
    logic [31:0] tbv[2];
    logic        tcv[2];
    logic [32:0] expv;
    int nacc;
    bit saw_ov;

    rst_n = 1'b0;
    vld = '0; ordy = '0;
    a = '0; b = '0; cin = 1'b0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(rdy[0]), 64'd0);
    check("rst_out_valid", 64'(ov[0]), 64'd0);
    check("rst_out_sum", 64'(os[0]), 64'd0);
    check("rst_out_cout", 64'(oc[0]), 64'd0);
    check("rst_add_a", 64'(m_add_a), 64'd0);
    check("rst_add_cin", 64'(m_add_cin), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 64'(rdy[0]), 64'd1);
    @(posedge clk); #1;

    // ---- carry ripple through all slices ----
    txn(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
    check("ripple_lat", 64'(lat), 64'd4);
    check("ripple_ncin", 64'(rec_cin.size()), 64'd4);
    if (rec_cin.size() == 4)
      check("ripple_cin_seq", 64'({rec_cin[3], rec_cin[2], rec_cin[1], rec_cin[0]}), 64'b1110);
    check("ripple_sum", 64'(os[0]), 64'h0);
    check("ripple_cout", 64'(oc[0]), 64'd1);
    check("done_add_a", 64'(m_add_a), 64'd0);
    check("done_add_cin", 64'(m_add_cin), 64'd0);
    release_out(0);

    // ---- slice ordering, carry-in ----
    txn(0, 32'h1234_5678, 32'h1111_1111, 1'b1, lat);
    check("order_lat", 64'(lat), 64'd4);
    check("order_na", 64'(rec_a.size()), 64'd4);
    if (rec_a.size() == 4)
      check("order_add_a", 64'({rec_a[3], rec_a[2], rec_a[1], rec_a[0]}), 64'h1234_5678);
    check("order_sum", 64'(os[0]), 64'h2345_678A);
    check("order_cout", 64'(oc[0]), 64'd0);
    release_out(0);

    // ---- hold result under back-pressure, ignore in_valid ----
    txn(0, 32'h0000_0005, 32'h0000_000A, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      if (i == 1 || i == 3) begin
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; cin = 1'b1;
        vld[0] = 1'b1;
      end
      check("hold_ov", 64'(ov[0]), 64'd1);
      check("hold_sum", 64'(os[0]), 64'hF);
      check("hold_cout", 64'(oc[0]), 64'd0);
      check("hold_ready", 64'(rdy[0]), 64'd0);
      @(posedge clk); #1;
      vld[0] = 1'b0;
    end
    check("hold_ov_end", 64'(ov[0]), 64'd1);
    check("hold_sum_end", 64'(os[0]), 64'hF);
    release_out(0);
    check("keep_sum", 64'(os[0]), 64'hF);

    // ---- reset during the second RUN cycle ----
    a = 32'h00FF_00FF; b = 32'h0101_0101; cin = 1'b0;
    vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_ov", 64'(ov[0]), 64'd0);
    check("abort_sum", 64'(os[0]), 64'd0);
    check("abort_cout", 64'(oc[0]), 64'd0);
    check("abort_ready", 64'(rdy[0]), 64'd0);
    check("abort_add_a", 64'(m_add_a), 64'd0);
    check("abort_add_b", 64'(m_add_b), 64'd0);
    check("abort_add_cin", 64'(m_add_cin), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_ready_back", 64'(rdy[0]), 64'd1);
    saw_ov = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ov[0]) saw_ov = 1'b1;
      @(posedge clk); #1;
    end
    check("abort_no_ov", 64'(saw_ov), 64'd0);
    txn(0, 32'd3, 32'd4, 1'b0, lat);
    check("after_abort_lat", 64'(lat), 64'd4);
    check("after_abort_sum", 64'(os[0]), 64'd7);
    check("after_abort_cout", 64'(oc[0]), 64'd0);
    release_out(0);

    // ---- back-to-back with in_valid and out_ready held high ----
    ta[0] = 32'hAAAA_5555; tbv[0] = 32'h5555_AAAA; tcv[0] = 1'b1;
    ta[1] = 32'h0000_FFFF; tbv[1] = 32'h0000_0001; tcv[1] = 1'b1;
    ordy[0] = 1'b1;
    vld[0] = 1'b1;
    nacc = 0;
    for (int c = 0; c < 20; c++) begin
      if (ov[0]) res.push_back({oc[0], os[0]});
      if (rdy[0]) begin
        if (nacc < 2) begin
          a = ta[nacc]; b = tbv[nacc]; cin = tcv[nacc];
          acc.push_back(c);
          nacc++;
        end else begin
          vld[0] = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    vld[0] = 1'b0;
    ordy[0] = 1'b0;
    check("b2b_naccept", 64'(acc.size()), 64'd2);
    if (acc.size() == 2)
      check("b2b_spacing", 64'(acc[1] - acc[0]), 64'd6);
    check("b2b_nresult", 64'(res.size()), 64'd2);
    if (res.size() == 2) begin
      check("b2b_res0", 64'(res[0]), 64'h1_0000_0000);
      check("b2b_res1", 64'(res[1]), 64'h0_0001_0001);
    end

    // ---- parameter sweep: one slice and 32 one-bit slices ----
    for (int k = 1; k <= 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (i == 0) begin
          ta[0] = 32'hFFFF_FFFF; tbv[0] = 32'h0; tcv[0] = 1'b1;
        end else begin
          ta[0] = $urandom; tbv[0] = $urandom; tcv[0] = 1'($urandom_range(0, 1));
        end
        expv = 33'(ta[0]) + 33'(tbv[0]) + 33'(tcv[0]);
        txn(k, ta[0], tbv[0], tcv[0], lat);
        check((k == 1) ? "sweep32_lat" : "sweep1_lat", 64'(lat), (k == 1) ? 64'd1 : 64'd32);
        check((k == 1) ? "sweep32_res" : "sweep1_res", 64'({oc[k], os[k]}), 64'(expv));
        release_out(k);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
